tx_stream_arbiter: RTL and testbench
====================================

Name: tx_stream_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single transmit AXI-stream port toward the router among NUM_SRC transport-layer sources (read-response packeting, ACK/NAK generator, control/credit messages).
- Sits between the tx packeting stage(s) and the router.
- A registered 2-entry skid buffer on the output gives full throughput and breaks the router-ready timing path.

Parameters:
- NUM_SRC, 2: number of requesting stream sources (2..8).
- DATA_W, 128: tdata width; tkeep width is DATA_W/8.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- io_src_valid  in  NUM_SRC  per-source tvalid.
- io_src_ready  out  NUM_SRC  per-source tready.
- io_src_tdata  in  NUM_SRC*DATA_W  flattened; source i occupies bits [i*DATA_W +: DATA_W].
- io_src_tkeep  in  NUM_SRC*DATA_W/8  flattened in the same way.
- io_src_tlast  in  NUM_SRC  per-source tlast.
- io_axi_str_to_router_ready  in  1  downstream tready.
- io_axi_str_to_router_valid  out  1  downstream tvalid.
- io_axi_str_to_router_bits_tdata  out  DATA_W
- io_axi_str_to_router_bits_tkeep  out  DATA_W/8
- io_axi_str_to_router_bits_tlast  out  1
- io_grant  out  NUM_SRC  one-hot current owner; all zero when IDLE.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, rr_ptr=0, skid buffer empty.
  - All outputs 0: io_src_ready, router valid/tdata/tkeep/tlast, io_grant.
- FSM states:
  - IDLE: if any io_src_valid, pick the first valid source at or after rr_ptr (modulo NUM_SRC). Register it as grant and go to BUSY next cycle. No beat is accepted in the IDLE cycle.
  - BUSY: io_src_ready[grant] = skid buffer not full (count<2); all other src_ready=0. A beat transfers on src_valid&src_ready and is written to the skid buffer.
  - BUSY, on a transferred beat with tlast=1: next state IDLE, rr_ptr = (grant+1) mod NUM_SRC, io_grant clears next cycle.
- Packet atomicity:
  - Grant is never changed mid-packet, even if the owner drops valid for any number of cycles.
  - Non-granted sources are never accepted.
- Skid buffer, 2 entries, FIFO order:
  - Output valid = count>0; output fields come from the head entry (registered, no comb path from src to router).
  - Simultaneous push and pop keeps count unchanged.
  - Push when full is impossible because src_ready is gated.
- Latency: a source asserting valid while IDLE sees its first beat on the router output 2 cycles later (arbitration cycle + register). Steady-state throughput is 1 beat/cycle while router ready=1.
- Bubble: one idle cycle between back-to-back packets for the arbitration cycle. This is accepted as a decided cost.
- Single-beat packet (tlast on first beat): returns to IDLE immediately after that beat.
- Router ready low: buffer fills to 2, then src_ready drops. Output fields stay stable while valid&!ready (AXIS rule).
- Reset mid-packet: everything clears, the partial packet is discarded, and sources must restart. This is system-level behaviour.

Optional Feature:
- Macro TX_ARB_STATS_EN.
- Defined: adds output io_pkt_count[NUM_SRC*32-1:0]. Each source has a 32-bit counter that increments on its accepted tlast beat, wraps at 2^32, and resets to 0.
- Undefined: no port, no counters. Logic is otherwise identical.

Decomposition:
- Shared package (doce_axis_pkg):
  - constant AXIS_DATA_W=128.
  - state enum {ARB_IDLE, ARB_BUSY}.
  - function rr_pick(valid, ptr) returning one-hot and index.
- One sub-module: axis_skid_buffer (2-entry register slice, DATA_W parameter), reusable elsewhere in the transport layer.

Test Plan:
- Reset with src0 valid and a 3-beat packet pending, router ready=1:
  - router valid=0 during reset.
  - After release, beats appear at cycles 2,3,4 with tdata=0xA0,0xA1,0xA2; tlast on 0xA2; io_grant=01 throughout.
- Both sources valid, rr_ptr=0, each sending 2-beat packets:
  - output order is src0 pkt, src1 pkt, src0 pkt.
  - exactly one bubble cycle between packets; no interleaving.
- Router ready held low for 5 cycles mid-packet:
  - buffer holds 2 beats and src_ready[grant]=0.
  - output tdata stable.
  - after ready rises, no beat is lost or duplicated.
- Owner drops valid for 4 cycles mid-packet while src1 valid:
  - io_grant stays on src0 and src1 is not accepted until src0's tlast.
- Single-beat packets alternating with NUM_SRC=3 and all sources valid:
  - grants cycle 0,1,2,0; tlast=1 on every output beat.
- TX_ARB_STATS_EN defined, 5 packets from src1:
  - io_pkt_count slice 1 = 5, slice 0 = 0.
  - reset clears both.

Source files
------------

// File: rtl/doce_axis_pkg.sv
// Shared transport-layer AXI-stream definitions: default data width, the
// arbiter state encoding and the round-robin pick helper.
package doce_axis_pkg;

    localparam int AXIS_DATA_W = 128;
    localparam int ARB_MAX_SRC = 8;
    localparam int ARB_IDX_W   = 3;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Result of a round-robin pick: index of the winner and its one-hot form.
    // An all-zero one-hot means no source is requesting.
    typedef struct packed {
        logic [ARB_IDX_W-1:0]   idx;
        logic [ARB_MAX_SRC-1:0] onehot;
    } rr_pick_t;

    // First requesting source at or after ptr, wrapping modulo num.
    // Scanning from the highest offset down lets the smallest offset win.
    function automatic rr_pick_t rr_pick(
        input logic [ARB_MAX_SRC-1:0] valid,
        input logic [ARB_IDX_W-1:0]   ptr,
        input logic [ARB_IDX_W:0]     num
    );
        rr_pick_t             pick_s;
        logic [ARB_IDX_W:0]   cand_s;
        logic [ARB_IDX_W:0]   wrap_s;
        pick_s = '0;
        for (int k = ARB_MAX_SRC - 1; k >= 0; k--) begin
            cand_s = {1'b0, ptr} + 4'(k);
            wrap_s = (cand_s >= num) ? (cand_s - num) : cand_s;
            if ((4'(k) < num) && valid[wrap_s[ARB_IDX_W-1:0]]) begin
                pick_s.idx    = wrap_s[ARB_IDX_W-1:0];
                pick_s.onehot = 8'b0000_0001 << wrap_s[ARB_IDX_W-1:0];
            end else begin
                pick_s = pick_s;
            end
        end
        return pick_s;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream register slice. Entry head_r always drives the
// output, so the downstream side sees only flops; in_ready depends only on
// the occupancy register, never on out_ready.
module axis_skid_buffer
    import doce_axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic [DATA_W/8-1:0] in_tkeep,
    input  logic                in_tlast,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_tdata,
    output logic [DATA_W/8-1:0] out_tkeep,
    output logic                out_tlast
);

    localparam int ENT_W = DATA_W + DATA_W / 8 + 1;

    logic [ENT_W-1:0] head_r;
    logic [ENT_W-1:0] tail_r;
    logic [1:0]       count_r;
    logic [ENT_W-1:0] in_ent_s;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign in_ent_s  = {in_tlast, in_tkeep, in_tdata};
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign {out_tlast, out_tkeep, out_tdata} = head_r;

    // FIFO-ordered storage: the head is refilled from the tail or the input on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= in_ent_s;
                    end else begin
                        tail_r <= in_ent_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= in_ent_s;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= in_ent_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing the router-bound AXI-stream port
// among NUM_SRC transport sources. One arbitration cycle precedes each packet;
// the grant is held until the owner's tlast beat is accepted.
// Optional build macro TX_ARB_STATS_EN adds per-source packet counters on
// io_pkt_count.
module tx_stream_arbiter
    import doce_axis_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = AXIS_DATA_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          io_src_valid,
    output logic [NUM_SRC-1:0]          io_src_ready,
    input  logic [NUM_SRC*DATA_W-1:0]   io_src_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0] io_src_tkeep,
    input  logic [NUM_SRC-1:0]          io_src_tlast,
    input  logic                        io_axi_str_to_router_ready,
    output logic                        io_axi_str_to_router_valid,
    output logic [DATA_W-1:0]           io_axi_str_to_router_bits_tdata,
    output logic [DATA_W/8-1:0]         io_axi_str_to_router_bits_tkeep,
    output logic                        io_axi_str_to_router_bits_tlast,
    output logic [NUM_SRC-1:0]          io_grant
`ifdef TX_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]       io_pkt_count
`endif
);

    localparam int KEEP_W = DATA_W / 8;

    arb_state_e                 state_r;
    logic [NUM_SRC-1:0]         grant_r;
    logic [ARB_IDX_W-1:0]       grant_idx_r;
    logic [ARB_IDX_W-1:0]       rr_ptr_r;

    logic [ARB_MAX_SRC-1:0]     valid_pad_s;
    rr_pick_t                   pick_s;
    logic                       pick_found_s;
    logic [ARB_IDX_W-1:0]       ptr_next_s;

    logic                       sel_valid_s;
    logic [DATA_W-1:0]          sel_tdata_s;
    logic [KEEP_W-1:0]          sel_tkeep_s;
    logic                       sel_tlast_s;
    logic                       skid_in_ready_s;
    logic                       beat_s;
    logic                       last_beat_s;

    // Round-robin candidate for the next packet, evaluated every cycle.
    always_comb begin
        valid_pad_s                = '0;
        valid_pad_s[NUM_SRC-1:0]   = io_src_valid;
        pick_s                     = rr_pick(valid_pad_s, rr_ptr_r, 4'(NUM_SRC));
        pick_found_s               = |pick_s.onehot;
        ptr_next_s                 = (grant_idx_r == 3'(NUM_SRC - 1)) ? 3'd0 : (grant_idx_r + 3'd1);
    end

    // AND-OR mux of the granted source; grant_r is all-zero while idle, so nothing passes.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_tdata_s = '0;
        sel_tkeep_s = '0;
        sel_tlast_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_valid_s = sel_valid_s | (io_src_valid[i] & grant_r[i]);
            sel_tdata_s = sel_tdata_s | (io_src_tdata[i*DATA_W +: DATA_W] & {DATA_W{grant_r[i]}});
            sel_tkeep_s = sel_tkeep_s | (io_src_tkeep[i*KEEP_W +: KEEP_W] & {KEEP_W{grant_r[i]}});
            sel_tlast_s = sel_tlast_s | (io_src_tlast[i] & grant_r[i]);
        end
    end

    assign io_src_ready = grant_r & {NUM_SRC{skid_in_ready_s}};
    assign beat_s       = sel_valid_s & skid_in_ready_s;
    assign last_beat_s  = beat_s & sel_tlast_s;
    assign io_grant     = grant_r;

    // Arbitration FSM: pick in IDLE, hold the owner through BUSY until its tlast beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ARB_IDLE;
            grant_r     <= '0;
            grant_idx_r <= 3'd0;
            rr_ptr_r    <= 3'd0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_found_s) begin
                        state_r     <= ARB_BUSY;
                        grant_r     <= pick_s.onehot[NUM_SRC-1:0];
                        grant_idx_r <= pick_s.idx;
                    end
                end
                ARB_BUSY: begin
                    if (last_beat_s) begin
                        state_r  <= ARB_IDLE;
                        grant_r  <= '0;
                        rr_ptr_r <= ptr_next_s;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    axis_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clock),
        .rst_n     (reset),
        .in_valid  (sel_valid_s),
        .in_ready  (skid_in_ready_s),
        .in_tdata  (sel_tdata_s),
        .in_tkeep  (sel_tkeep_s),
        .in_tlast  (sel_tlast_s),
        .out_valid (io_axi_str_to_router_valid),
        .out_ready (io_axi_str_to_router_ready),
        .out_tdata (io_axi_str_to_router_bits_tdata),
        .out_tkeep (io_axi_str_to_router_bits_tkeep),
        .out_tlast (io_axi_str_to_router_bits_tlast)
    );

`ifdef TX_ARB_STATS_EN
    logic [NUM_SRC*32-1:0] pkt_count_r;

    // Per-source count of accepted tlast beats, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_count_r <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (last_beat_s && grant_r[i]) begin
                    pkt_count_r[i*32 +: 32] <= pkt_count_r[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign io_pkt_count = pkt_count_r;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Self-checking bench for tx_stream_arbiter (NUM_SRC=3). Each scenario is a
// set of source beats and an expected router-side beat list with the cycle
// each beat is accepted, counted from reset release.
module tb_tx_stream_arbiter;

    localparam int NS = 3;
    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int HN = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NS-1:0]     io_src_valid;
    logic [NS-1:0]     io_src_ready;
    logic [NS*DW-1:0]  io_src_tdata;
    logic [NS*KW-1:0]  io_src_tkeep;
    logic [NS-1:0]     io_src_tlast;
    logic              router_ready;
    logic              router_valid;
    logic [DW-1:0]     router_tdata;
    logic [KW-1:0]     router_tkeep;
    logic              router_tlast;
    logic [NS-1:0]     io_grant;
`ifdef TX_ARB_STATS_EN
    logic [NS*32-1:0]  pkt_count;
`endif

    tx_stream_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clock                           (clock),
        .reset                           (reset),
        .io_src_valid                    (io_src_valid),
        .io_src_ready                    (io_src_ready),
        .io_src_tdata                    (io_src_tdata),
        .io_src_tkeep                    (io_src_tkeep),
        .io_src_tlast                    (io_src_tlast),
        .io_axi_str_to_router_ready      (router_ready),
        .io_axi_str_to_router_valid      (router_valid),
        .io_axi_str_to_router_bits_tdata (router_tdata),
        .io_axi_str_to_router_bits_tkeep (router_tkeep),
        .io_axi_str_to_router_bits_tlast (router_tlast),
        .io_grant                        (io_grant)
`ifdef TX_ARB_STATS_EN
        ,
        .io_pkt_count                    (pkt_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] data; logic last; } beat_t;
    typedef struct { int scen; int src; logic [7:0] data; logic last; } stim_t;
    typedef struct { int scen; logic [7:0] data; logic last; int cyc; } exp_t;
    typedef struct { logic [DW-1:0] tdata; logic [KW-1:0] tkeep; logic tlast; int cyc; } cap_t;

    beat_t srcq [NS][$];
    stim_t stim [$];
    exp_t  expv [$];
    cap_t  cap  [$];

    logic [NS-1:0] hist_grant  [HN];
    logic [NS-1:0] hist_sready [HN];
    logic          hist_rvalid [HN];
    logic [DW-1:0] hist_rdata  [HN];

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;
    int hold_src = -1, hold_from = -1, hold_to = -1;
    int lo_from  = -1, lo_to = -1;

    function automatic logic [DW-1:0] wide(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [KW-1:0] keep_of(input logic last);
        return last ? 16'h00FF : 16'hFFFF;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive();
        beat_t h;
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                h = srcq[i][0];
                io_src_valid[i]            = !(i == hold_src && cyc >= hold_from && cyc <= hold_to);
                io_src_tdata[i*DW +: DW]   = wide(h.data);
                io_src_tkeep[i*KW +: KW]   = keep_of(h.last);
                io_src_tlast[i]            = h.last;
            end else begin
                io_src_valid[i]            = 1'b0;
                io_src_tdata[i*DW +: DW]   = '0;
                io_src_tkeep[i*KW +: KW]   = '0;
                io_src_tlast[i]            = 1'b0;
            end
        end
        router_ready = !(cyc >= lo_from && cyc <= lo_to);
    endtask

    task automatic tick();
        logic [NS-1:0] acc;
        cap_t c;
        @(negedge clock);
        if (cyc < HN) begin
            hist_grant[cyc]  = io_grant;
            hist_sready[cyc] = io_src_ready;
            hist_rvalid[cyc] = router_valid;
            hist_rdata[cyc]  = router_tdata;
        end
        chk($sformatf("ready_ungranted_c%0d", cyc), DW'(io_src_ready & ~io_grant), '0);
        acc = io_src_valid & io_src_ready;
        if (router_valid && router_ready) begin
            c.tdata = router_tdata;
            c.tkeep = router_tkeep;
            c.tlast = router_tlast;
            c.cyc   = cyc;
            cap.push_back(c);
        end
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) void'(srcq[i].pop_front());
        end
        drive();
    endtask

    task automatic run_scen(input int s, input int ncyc);
        beat_t b;
        int    k;
        reset = 1'b0;
        for (int i = 0; i < NS; i++) srcq[i].delete();
        for (int e = 0; e < stim.size(); e++) begin
            if (stim[e].scen == s) begin
                b.data = stim[e].data;
                b.last = stim[e].last;
                srcq[stim[e].src].push_back(b);
            end
        end
        cap.delete();
        for (int c = 0; c < HN; c++) begin
            hist_grant[c] = '0; hist_sready[c] = '0; hist_rvalid[c] = 1'b0; hist_rdata[c] = '0;
        end
        cyc = 0;
        drive();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk($sformatf("s%0d_rst_valid", s), DW'(router_valid), '0);
        chk($sformatf("s%0d_rst_tdata", s), router_tdata, '0);
        chk($sformatf("s%0d_rst_tkeep", s), DW'(router_tkeep), '0);
        chk($sformatf("s%0d_rst_tlast", s), DW'(router_tlast), '0);
        chk($sformatf("s%0d_rst_sready", s), DW'(io_src_ready), '0);
        chk($sformatf("s%0d_rst_grant", s), DW'(io_grant), '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc = 0;
        drive();
        repeat (ncyc) tick();
        k = 0;
        for (int e = 0; e < expv.size(); e++) begin
            if (expv[e].scen == s) begin
                if (k < cap.size()) begin
                    chk($sformatf("s%0d_b%0d_tdata", s, k), cap[k].tdata, wide(expv[e].data));
                    chk($sformatf("s%0d_b%0d_tkeep", s, k), DW'(cap[k].tkeep), DW'(keep_of(expv[e].last)));
                    chk($sformatf("s%0d_b%0d_tlast", s, k), DW'(cap[k].tlast), DW'(expv[e].last));
                    chk($sformatf("s%0d_b%0d_cycle", s, k), DW'(cap[k].cyc), DW'(expv[e].cyc));
                end
                k++;
            end
        end
        chk($sformatf("s%0d_beat_count", s), DW'(cap.size()), DW'(k));
        hold_src = -1; hold_from = -1; hold_to = -1; lo_from = -1; lo_to = -1;
    endtask

    task automatic add_s(input int s, input int src, input logic [7:0] d, input logic l);
        stim_t t;
        t.scen = s; t.src = src; t.data = d; t.last = l;
        stim.push_back(t);
    endtask

    task automatic add_e(input int s, input logic [7:0] d, input logic l, input int c);
        exp_t t;
        t.scen = s; t.data = d; t.last = l; t.cyc = c;
        expv.push_back(t);
    endtask

    initial begin
        reset = 1'b0;
        io_src_valid = '0; io_src_tdata = '0; io_src_tkeep = '0; io_src_tlast = '0;
        router_ready = 1'b1;

        // 1: single 3-beat packet from src0 pending through reset
        add_s(1, 0, 8'hA0, 1'b0); add_s(1, 0, 8'hA1, 1'b0); add_s(1, 0, 8'hA2, 1'b1);
        add_e(1, 8'hA0, 1'b0, 2); add_e(1, 8'hA1, 1'b0, 3); add_e(1, 8'hA2, 1'b1, 4);
        // 2: round robin src0, src1, src0 with one bubble per packet
        add_s(2, 0, 8'hA0, 1'b0); add_s(2, 0, 8'hA1, 1'b1); add_s(2, 0, 8'hA2, 1'b0); add_s(2, 0, 8'hA3, 1'b1);
        add_s(2, 1, 8'hB0, 1'b0); add_s(2, 1, 8'hB1, 1'b1);
        add_e(2, 8'hA0, 1'b0, 2); add_e(2, 8'hA1, 1'b1, 3); add_e(2, 8'hB0, 1'b0, 5);
        add_e(2, 8'hB1, 1'b1, 6); add_e(2, 8'hA2, 1'b0, 8); add_e(2, 8'hA3, 1'b1, 9);
        // 3: router ready low for cycles 3..7 inside a 6-beat packet
        for (int i = 0; i < 6; i++) add_s(3, 0, 8'(8'hA0 + i), (i == 5));
        add_e(3, 8'hA0, 1'b0, 2);
        for (int i = 1; i < 6; i++) add_e(3, 8'(8'hA0 + i), (i == 5), 7 + i);
        // 4: owner src0 drops valid for cycles 3..6 while src1 waits
        for (int i = 0; i < 4; i++) add_s(4, 0, 8'(8'hA0 + i), (i == 3));
        add_s(4, 1, 8'hB0, 1'b0); add_s(4, 1, 8'hB1, 1'b1);
        add_e(4, 8'hA0, 1'b0, 2); add_e(4, 8'hA1, 1'b0, 3); add_e(4, 8'hA2, 1'b0, 8);
        add_e(4, 8'hA3, 1'b1, 9); add_e(4, 8'hB0, 1'b0, 11); add_e(4, 8'hB1, 1'b1, 12);
        // 5: single-beat packets, all three sources valid
        add_s(5, 0, 8'hA0, 1'b1); add_s(5, 0, 8'hA1, 1'b1); add_s(5, 1, 8'hB0, 1'b1); add_s(5, 2, 8'hC0, 1'b1);
        add_e(5, 8'hA0, 1'b1, 2); add_e(5, 8'hB0, 1'b1, 4); add_e(5, 8'hC0, 1'b1, 6); add_e(5, 8'hA1, 1'b1, 8);
        // 6: five single-beat packets from src1
        for (int i = 0; i < 5; i++) begin
            add_s(6, 1, 8'(8'hB0 + i), 1'b1);
            add_e(6, 8'(8'hB0 + i), 1'b1, 2 + 2 * i);
        end

        run_scen(1, 20);
        chk("s1_idle_grant", DW'(hist_grant[0]), '0);
        chk("s1_idle_sready", DW'(hist_sready[0]), '0);
        chk("s1_no_early_valid", DW'(hist_rvalid[1]), '0);
        for (int c = 1; c <= 3; c++) chk($sformatf("s1_grant_c%0d", c), DW'(hist_grant[c]), DW'(3'b001));

        run_scen(2, 20);
        chk("s2_bubble_c4", DW'(hist_rvalid[4]), '0);
        chk("s2_bubble_c7", DW'(hist_rvalid[7]), '0);
        chk("s2_arb_idle_c3", DW'(hist_grant[3]), '0);
        chk("s2_grant_c4", DW'(hist_grant[4]), DW'(3'b010));

        lo_from = 3; lo_to = 7;
        run_scen(3, 20);
        for (int c = 3; c <= 7; c++) begin
            chk($sformatf("s3_stall_valid_c%0d", c), DW'(hist_rvalid[c]), DW'(1'b1));
            chk($sformatf("s3_stall_tdata_c%0d", c), hist_rdata[c], wide(8'hA1));
        end
        for (int c = 4; c <= 7; c++) chk($sformatf("s3_stall_sready_c%0d", c), DW'(hist_sready[c]), '0);

        hold_src = 0; hold_from = 3; hold_to = 6;
        run_scen(4, 20);
        for (int c = 3; c <= 6; c++) chk($sformatf("s4_hold_grant_c%0d", c), DW'(hist_grant[c]), DW'(3'b001));
        chk("s4_src1_wait_c9", DW'(hist_grant[9]), '0);
        chk("s4_src1_grant_c10", DW'(hist_grant[10]), DW'(3'b010));

        run_scen(5, 20);
        chk("s5_grant_c1", DW'(hist_grant[1]), DW'(3'b001));
        chk("s5_grant_c2", DW'(hist_grant[2]), '0);
        chk("s5_grant_c3", DW'(hist_grant[3]), DW'(3'b010));
        chk("s5_grant_c5", DW'(hist_grant[5]), DW'(3'b100));
        chk("s5_grant_c7", DW'(hist_grant[7]), DW'(3'b001));

`ifdef TX_ARB_STATS_EN
        run_scen(6, 16);
        chk("s6_count_src1", DW'(pkt_count[63:32]), DW'(32'd5));
        chk("s6_count_src0", DW'(pkt_count[31:0]), '0);
        reset = 1'b0;
        #2;
        chk("s6_rst_count_src1", DW'(pkt_count[63:32]), '0);
        chk("s6_rst_count_src0", DW'(pkt_count[31:0]), '0);
        reset = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
